// File: rtl/bayes_ctrl_pkg.sv
// Shared types for the likelihood-array sequencer: FSM state encoding and mode constants.
package bayes_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_OBS  = 3'd1,
      LOAD_SEED = 3'd2,
      INFER     = 3'd3,
      DRAIN     = 3'd4,
      READOUT   = 3'd5,
      DECIDE    = 3'd6,
      DONE      = 3'd7
   } ctrl_state_t;

   localparam logic MODE_STOCH = 1'b0;
   localparam logic MODE_LOG   = 1'b1;

endpackage

// File: rtl/bayes_argmax.sv
// Combinational arg-max over the packed per-class score vector; lowest index wins ties.
// Zero latency, no flow control; tie flags any other class equal to the maximum.
module bayes_argmax #(
   parameter int Narray = 2,
   parameter int CNT_W  = 10
) (
   input  logic [(2**Narray)*CNT_W-1:0] scores,
   output logic [Narray-1:0]            idx,
   output logic [CNT_W-1:0]             max_val,
   output logic                         tie
);

   localparam int NCLS = 2**Narray;

   always_comb begin
      idx     = '0;
      max_val = scores[CNT_W-1:0];
      tie     = 1'b0;
      // strict greater-than keeps the earliest index on equal scores
      for (int i = 1; i < NCLS; i++) begin
         if (scores[i*CNT_W +: CNT_W] > max_val) begin
            max_val = scores[i*CNT_W +: CNT_W];
            idx     = Narray'(i);
         end
      end
      for (int i = 0; i < NCLS; i++) begin
         if ((Narray'(i) != idx) && (scores[i*CNT_W +: CNT_W] == max_val)) begin
            tie = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bayes_inference_ctrl.sv
// Sequencer for the likelihood array: load obs/seed, run inference or log read-out, report arg-max class.
// start->done is n+8 (stochastic) or n+17 (log) cycles; start is ignored while busy.
module bayes_inference_ctrl
   import bayes_ctrl_pkg::*;
#(
   parameter int Narray     = 2,
   parameter int Nword      = 6,
   parameter int N          = Narray + Nword,
   parameter int Nword_used = 3,
   parameter int CNT_W      = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          mode,
   input  logic [(2**Narray)*Nword-1:0]  obs,
   input  logic [2**Nword_used-1:0]      seed_in,
   input  logic [CNT_W-1:0]              n_cycles,
   input  logic [2**Narray-1:0]          bit_out,
   output logic                          inference,
   output logic                          load_seed,
   output logic                          load_mem,
   output logic                          read_out,
   output logic                          read_1,
   output logic                          read_8,
   output logic                          stoch_log,
   output logic [2**Nword_used-1:0]      seeds,
   output logic [N-1:0]                  adr_full_col,
   output logic [N-1:0]                  adr_full_row,
   output logic                          busy,
   output logic                          done,
   output logic [Narray-1:0]             winner,
   output logic [CNT_W-1:0]              win_score,
   output logic                          tie
);

   localparam int               NCLS      = 2**Narray;
   localparam int               RD_LEN    = 2**Nword_used;
   localparam logic [CNT_W-1:0] SCORE_MAX = '1;

   ctrl_state_t                   state, state_nxt;
   logic [CNT_W-1:0]              cnt, cnt_nxt;
   logic [CNT_W-1:0]              n_lat;
   logic [NCLS*Nword-1:0]         obs_lat, obs_src;
   logic [Narray-1:0]             col_nxt;
   logic [Nword-1:0]              obs_word;
   logic                          infer_d, rd_d;
   logic                          accept;
   logic [NCLS-1:0][CNT_W-1:0]    score;
   logic [NCLS*CNT_W-1:0]         score_flat;
   logic [Narray-1:0]             am_idx;
   logic [CNT_W-1:0]              am_max;
   logic                          am_tie;

   assign read_1     = 1'b0;
   assign read_8     = 1'b0;
   assign accept     = (state == IDLE) && start;
   assign score_flat = score;

   // column addresses for the first LOAD_OBS cycle are formed before obs_lat is loaded
   assign obs_src  = (state == IDLE) ? obs : obs_lat;
   assign col_nxt  = cnt_nxt[Narray-1:0];
   assign obs_word = obs_src[col_nxt*Nword +: Nword];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD_OBS;
               cnt_nxt   = '0;
            end
         end
         LOAD_OBS: begin
            if (cnt == CNT_W'(NCLS - 1)) begin
               state_nxt = LOAD_SEED;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         LOAD_SEED: begin
            state_nxt = INFER;
            cnt_nxt   = '0;
         end
         INFER: begin
            if (cnt == n_lat - 1'b1) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DRAIN: begin
            state_nxt = (stoch_log == MODE_LOG) ? READOUT : DECIDE;
            cnt_nxt   = '0;
         end
         READOUT: begin
            // one extra cycle so the bit of the last read_out strobe is captured
            if (cnt == CNT_W'(RD_LEN)) begin
               state_nxt = DECIDE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DECIDE:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // all strobes are decoded from the next state so they are flop outputs aligned with their state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         n_lat        <= '0;
         obs_lat      <= '0;
         stoch_log    <= 1'b0;
         seeds        <= '0;
         load_mem     <= 1'b0;
         load_seed    <= 1'b0;
         inference    <= 1'b0;
         read_out     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         adr_full_col <= '0;
         adr_full_row <= '0;
         infer_d      <= 1'b0;
         rd_d         <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            obs_lat   <= obs;
            n_lat     <= (n_cycles == '0) ? CNT_W'(1) : n_cycles;
            stoch_log <= mode;
            seeds     <= seed_in;
         end
         load_mem  <= (state_nxt == LOAD_OBS);
         load_seed <= (state_nxt == LOAD_SEED);
         inference <= (state_nxt == INFER);
         read_out  <= (state_nxt == READOUT) && (cnt_nxt < CNT_W'(RD_LEN));
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
         if (state_nxt == LOAD_OBS) begin
            adr_full_col <= {col_nxt, obs_word};
            adr_full_row <= {{Narray{1'b0}}, obs_word};
         end else begin
            adr_full_col <= '0;
            adr_full_row <= '0;
         end
         infer_d <= inference && (stoch_log == MODE_STOCH);
         rd_d    <= read_out;
      end
   end

   // array data lags its strobe by one cycle, hence the delayed enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score <= '0;
      end else if (accept) begin
         score <= '0;
      end else begin
         for (int k = 0; k < NCLS; k++) begin
            if (infer_d && bit_out[k] && (score[k] != SCORE_MAX)) begin
               score[k] <= score[k] + 1'b1;
            end else if (rd_d) begin
               score[k] <= {score[k][CNT_W-2:0], bit_out[k]};
            end
         end
      end
   end

   bayes_argmax #(
      .Narray (Narray),
      .CNT_W  (CNT_W)
   ) u_argmax (
      .scores  (score_flat),
      .idx     (am_idx),
      .max_val (am_max),
      .tie     (am_tie)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         winner    <= '0;
         win_score <= '0;
         tie       <= 1'b0;
      end else if (state == DECIDE) begin
         winner    <= am_idx;
         win_score <= am_max;
         tie       <= am_tie;
      end
   end

endmodule

// File: tb/tb_bayes_inference_ctrl.sv
// Scoreboard bench for bayes_inference_ctrl: directed transactions push expected results, a negedge monitor checks them.
module tb_bayes_inference_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [23:0] obs;
   logic [7:0]  seed_in;
   logic [9:0]  n_cycles;
   logic [3:0]  bit_out;
   logic        inference, load_seed, load_mem, read_out, read_1, read_8, stoch_log;
   logic [7:0]  seeds;
   logic [7:0]  adr_full_col, adr_full_row;
   logic        busy, done;
   logic [1:0]  winner;
   logic [9:0]  win_score;
   logic        tie;

   bayes_inference_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .mode         (mode),
      .obs          (obs),
      .seed_in      (seed_in),
      .n_cycles     (n_cycles),
      .bit_out      (bit_out),
      .inference    (inference),
      .load_seed    (load_seed),
      .load_mem     (load_mem),
      .read_out     (read_out),
      .read_1       (read_1),
      .read_8       (read_8),
      .stoch_log    (stoch_log),
      .seeds        (seeds),
      .adr_full_col (adr_full_col),
      .adr_full_row (adr_full_row),
      .busy         (busy),
      .done         (done),
      .winner       (winner),
      .win_score    (win_score),
      .tie          (tie)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  winner;
      logic [9:0]  score;
      logic        tie;
      int          lat;
      int          n_inf;
      int          n_rd;
      logic [23:0] obs;
      logic [7:0]  seed;
      logic        mode;
      int          t0;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endfunction

   // array model for log read-out: the bit for strobe i appears in the cycle after it
   logic       log_drv = 1'b0;
   logic [7:0] lw [4];
   logic       rd_prev = 1'b0;
   int         rd_idx = 0;
   always @(negedge clk) begin
      if (log_drv) begin
         if (!busy) begin
            rd_idx  = 0;
            rd_prev = 1'b0;
            bit_out = 4'b0000;
         end else begin
            if (rd_prev && rd_idx < 8) begin
               for (int k = 0; k < 4; k++) begin
                  logic [7:0] w;
                  w = lw[k];
                  bit_out[k] = w[7 - rd_idx];
               end
               rd_idx++;
            end
            rd_prev = read_out;
         end
      end
   end

   // monitor: counts strobes per transaction, checks addresses/seed live and the result at done
   int         n_load = 0, n_seed = 0, n_inf = 0, n_rd = 0, n_excl = 0;
   exp_t       cur;
   logic [5:0] ow;
   always @(negedge clk) begin
      if (!busy) begin
         n_load = 0; n_seed = 0; n_inf = 0; n_rd = 0; n_excl = 0;
      end else begin
         if ($countones({load_mem, load_seed, inference, read_out}) > 1) n_excl++;
         if (load_mem) begin
            if (exp_q.size() > 0 && n_load < 4) begin
               cur = exp_q[0];
               ow  = cur.obs[n_load*6 +: 6];
               check("adr_full_col", adr_full_col, {n_load[1:0], ow});
               check("adr_full_row", adr_full_row, {2'b00, ow});
            end
            n_load++;
         end
         if (load_seed) begin
            if (exp_q.size() > 0) begin
               cur = exp_q[0];
               check("seeds", seeds, cur.seed);
               check("stoch_log", stoch_log, cur.mode);
            end
            n_seed++;
         end
         if (inference) n_inf++;
         if (read_out) n_rd++;
         if (done) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
               cur = exp_q.pop_front();
               check("winner", winner, cur.winner);
               check("win_score", win_score, cur.score);
               check("tie", tie, cur.tie);
               check("latency", cyc - cur.t0, cur.lat);
               check("load_mem_cycles", n_load, 4);
               check("load_seed_cycles", n_seed, 1);
               check("inference_cycles", n_inf, cur.n_inf);
               check("read_out_cycles", n_rd, cur.n_rd);
               check("strobe_exclusive", n_excl, 0);
            end
         end
      end
   end

   task automatic run_txn(input logic m, input logic [9:0] n, input logic [3:0] bo,
                          input logic [23:0] ob, input logic [7:0] sd,
                          input logic [1:0] w, input logic [9:0] s, input logic t,
                          input int lat, input int ninf, input int nrd, input logic abuse);
      exp_t e;
      int   k;
      @(negedge clk);
      e.winner = w; e.score = s; e.tie = t; e.lat = lat; e.n_inf = ninf; e.n_rd = nrd;
      e.obs = ob; e.seed = sd; e.mode = m; e.t0 = cyc;
      exp_q.push_back(e);
      mode = m; obs = ob; seed_in = sd; n_cycles = n; bit_out = bo; log_drv = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (abuse) begin
         k = 0;
         while (!inference && k < 50) begin @(negedge clk); k++; end
         repeat (3) @(negedge clk);
         mode = ~m; n_cycles = 10'd3; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      k = 0;
      while (!done && k < 3000) begin @(negedge clk); k++; end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
         exp_q.delete();
      end else if (abuse) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("start_at_done_ignored_busy", busy, 1'b0);
      end
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; obs = '0; seed_in = '0;
      n_cycles = '0; bit_out = '0;
      for (int i = 0; i < 4; i++) lw[i] = 8'h00;

      // start while in reset must not launch anything
      repeat (2) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      check("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_strobes", {load_mem, load_seed, inference, read_out, read_1, read_8, done, tie}, 8'h00);
      check("idle_results", {winner, win_score, seeds, stoch_log}, 21'h0);
      check("idle_addr", {adr_full_col, adr_full_row}, 16'h0000);

      // stochastic, single responding class
      run_txn(1'b0, 10'd20, 4'b0100, {6'h3F, 6'h2A, 6'h11, 6'h05}, 8'hA5,
              2'd2, 10'd20, 1'b0, 28, 20, 0, 1'b0);
      // two classes reach full scale together
      run_txn(1'b0, 10'd1023, 4'b1010, {6'h01, 6'h02, 6'h03, 6'h04}, 8'h3C,
              2'd1, 10'd1023, 1'b1, 1031, 1023, 0, 1'b0);
      // zero cycle count runs once; scores from the previous run are cleared
      run_txn(1'b0, 10'd0, 4'b0001, {6'h10, 6'h20, 6'h30, 6'h00}, 8'h01,
              2'd0, 10'd1, 1'b0, 9, 1, 0, 1'b0);
      // log read-out
      lw[0] = 8'h3C; lw[1] = 8'h00; lw[2] = 8'h00; lw[3] = 8'hF0;
      run_txn(1'b1, 10'd4, 4'b0000, {6'h0A, 6'h0B, 6'h0C, 6'h0D}, 8'h5A,
              2'd3, 10'd240, 1'b0, 21, 4, 8, 1'b0);
      // start pulses while busy, and one coincident with done
      run_txn(1'b0, 10'd20, 4'b0100, {6'h15, 6'h2B, 6'h07, 6'h38}, 8'hC3,
              2'd2, 10'd20, 1'b0, 28, 20, 0, 1'b1);

      // reset in the middle of READOUT
      @(negedge clk);
      lw[0] = 8'hFF; lw[1] = 8'hFF; lw[2] = 8'hFF; lw[3] = 8'hFF;
      mode = 1'b1; n_cycles = 10'd2; bit_out = 4'b0000; log_drv = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!read_out && k < 50) begin @(negedge clk); k++; end
      check("readout_reached", read_out, 1'b1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_read_out", read_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_strobes", {load_mem, load_seed, inference, done}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", busy, 1'b0);

      // fresh runs after the abort
      run_txn(1'b0, 10'd5, 4'b1000, {6'h22, 6'h33, 6'h01, 6'h3E}, 8'h77,
              2'd3, 10'd5, 1'b0, 13, 5, 0, 1'b0);
      lw[0] = 8'h10; lw[1] = 8'h81; lw[2] = 8'h81; lw[3] = 8'h7F;
      run_txn(1'b1, 10'd1, 4'b0000, {6'h3A, 6'h1B, 6'h2C, 6'h0D}, 8'h99,
              2'd1, 10'd129, 1'b1, 18, 1, 8, 1'b0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by time %0t expected finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
